alu_seq: RTL and testbench
==========================

// Module: alu_seq
//
// PURPOSE
//   Parametrised multi-cycle ALU, successor to the single-cycle datapath ALU.
//   - Adds registered results, status flags and a Start/Busy/Done handshake.
//   - Adds a full-width product via an iterative shift-add multiplier.
//   Sits between the register file read ports and the write-back/memory stage.
//   The control unit issues one operation and stalls on Busy until Done.
//
// PARAMETERS
//   DATA_WIDTH  8  operand/result width in bits, >= 2
//   CNT_WIDTH   $clog2(DATA_WIDTH)+1  width of the multiply step counter
//
// PORTS
//   Clk       in   1            rising-edge clock
//   Rst_n     in   1            asynchronous, active-low reset
//   Start     in   1            request; sampled only while Busy=0
//   Alu_Op    in   3            000 ADD, 001 SUB, 010 MUL, 011 PASS, 100 AND,
//                               101 OR, 110 XOR, 111 illegal
//   Reg1_Out  in   DATA_WIDTH   operand A
//   Reg2_Out  in   DATA_WIDTH   operand B (PASS forwards B)
//   Alu_Out   out  DATA_WIDTH   registered result (MUL: low half of product)
//   Alu_Hi    out  DATA_WIDTH   MUL: high half of product; 0 for all other ops
//   Busy      out  1            operation in progress; Start ignored
//   Done      out  1            one-cycle pulse: Alu_Out, Alu_Hi and flags updated
//   Zero      out  1            result == 0 (MUL: full 2*DATA_WIDTH product == 0)
//   Carry     out  1            ADD carry-out; SUB borrow (A < B unsigned); else 0
//   Ovf       out  1            ADD/SUB two's-complement overflow; MUL Alu_Hi != 0; else 0
//   Err       out  1            set with Done when Alu_Op=111; else 0
//
// BEHAVIOUR
//   Reset (Rst_n=0, asynchronous, any state, including mid-MUL):
//   - State=IDLE; in-flight operation is discarded.
//   - All outputs=0; operand and accumulator registers=0.
//   FSM states are IDLE and MUL.
//   IDLE, Start=1, Alu_Op != MUL, sampled on edge k:
//   - Result and flags are registered on edge k; Done=1 for cycle k+1 only.
//   - Busy stays 0; state stays IDLE. Latency is 1 cycle.
//   IDLE, Start=1, Alu_Op = MUL, sampled on edge k:
//   - A and B are captured; accumulator=0; counter=DATA_WIDTH.
//   - Busy=1; state goes to MUL.
//   MUL state, edges k+1 .. k+DATA_WIDTH:
//   - One shift-add step per edge, LSB of multiplier first; counter decrements.
//   - On the step where the counter reaches 0: state goes to IDLE.
//   - On that same edge: Busy=0, Done=1, and Alu_Hi/Alu_Out/flags are written.
//   - Latency is DATA_WIDTH+1 cycles. Product is unsigned, 2*DATA_WIDTH bits.
//   Start while Busy=1: ignored. Operands on the inputs are not re-sampled.
//   Back-to-back: Start is accepted in the same cycle Done=1, since Busy=0 then.
//   Between completions: Alu_Out, Alu_Hi and all flags hold their last values.
//   Width rules:
//   - ADD/SUB use DATA_WIDTH+1 internal bits; the MSB is Carry.
//   - Results wrap modulo 2^DATA_WIDTH.
//   - Ovf for ADD/SUB = sign(A) vs sign(B') vs sign(result) rule, where B' = ~B for SUB.
//   Illegal op (111):
//   - Alu_Out=0, Alu_Hi=0, Zero=1, Carry=0, Ovf=0, Err=1.
//   - Completes with 1-cycle latency, same as other single-cycle ops.
//   Err clears on the next completion of any legal op.
//
// TESTING (DATA_WIDTH=8)
//   ADD FF+01 -> Done 1 cycle after Start; Alu_Out=00, Zero=1, Carry=1, Ovf=0, Busy never 1
//   SUB 80-01 -> Alu_Out=7F, Ovf=1, Carry=0; SUB 01-02 -> Alu_Out=FF, Carry=1
//   MUL FF*FF -> Busy for 8 cycles; Done exactly 9 cycles after Start; Alu_Hi=FE, Alu_Out=01, Ovf=1
//   MUL 0C*0A, Start pulsed again mid-op with ADD -> second Start ignored; Alu_Out=78, Alu_Hi=00, Ovf=0
//   Rst_n low 4 cycles into a MUL -> all outputs 0 at once; next ADD 02+03 gives Alu_Out=05
//   MUL then ADD issued on the Done cycle -> ADD accepted; Done pulses again 1 cycle later; Op 111 -> Err=1, Zero=1

Source files
------------

// File: rtl/alu_seq.sv
// -----------------------------------------------------------------------------
// alu_seq -- multi-cycle ALU with registered result, status flags and a
// Start/Busy/Done handshake. Single-cycle ops (ADD, SUB, PASS, AND, OR, XOR,
// illegal) complete one cycle after Start. MUL runs an iterative shift-add
// multiplier that produces a full 2*DATA_WIDTH-bit unsigned product.
//
// Ports
//   Clk       in   rising-edge clock
//   Rst_n     in   asynchronous active-low reset
//   Start     in   operation request, sampled only while Busy=0
//   Alu_Op    in   000 ADD, 001 SUB, 010 MUL, 011 PASS, 100 AND, 101 OR,
//                  110 XOR, 111 illegal
//   Reg1_Out  in   operand A
//   Reg2_Out  in   operand B (PASS forwards B)
//   Alu_Out   out  registered result (MUL: low half of product)
//   Alu_Hi    out  MUL high half of product, 0 for all other ops
//   Busy      out  multiply in progress, Start ignored
//   Done      out  one-cycle pulse when result and flags were updated
//   Zero      out  result == 0 (MUL: full product == 0)
//   Carry     out  ADD carry-out, SUB borrow, else 0
//   Ovf       out  ADD/SUB signed overflow, MUL high half non-zero, else 0
//   Err       out  illegal opcode completed, cleared by next legal completion
// -----------------------------------------------------------------------------
module alu_seq #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  Start,
  input  logic [2:0]            Alu_Op,
  input  logic [DATA_WIDTH-1:0] Reg1_Out,
  input  logic [DATA_WIDTH-1:0] Reg2_Out,
  output logic [DATA_WIDTH-1:0] Alu_Out,
  output logic [DATA_WIDTH-1:0] Alu_Hi,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Zero,
  output logic                  Carry,
  output logic                  Ovf,
  output logic                  Err
);

  localparam int W  = DATA_WIDTH;
  localparam int PW = 2 * DATA_WIDTH;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MUL  = 3'b010;
  localparam logic [2:0] OP_PASS = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t          r_state, w_state_next;

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right
  // so that bit 0 of r_mplier is always the bit being consumed this step.
  logic [PW-1:0]        r_mcand,  w_mcand_next;
  logic [W-1:0]         r_mplier, w_mplier_next;
  logic [PW-1:0]        r_acc,    w_acc_next;
  logic [CNT_WIDTH-1:0] r_cnt,    w_cnt_next;

  logic [W-1:0] r_out,   w_out_next;
  logic [W-1:0] r_hi,    w_hi_next;
  logic         r_busy,  w_busy_next;
  logic         r_done,  w_done_next;
  logic         r_zero,  w_zero_next;
  logic         r_carry, w_carry_next;
  logic         r_ovf,   w_ovf_next;
  logic         r_err,   w_err_next;

  // One extra bit so the MSB is the ADD carry / SUB borrow.
  logic [W:0]    w_sum;
  logic [W:0]    w_diff;
  logic [PW-1:0] w_step_acc;
  logic          w_add_ovf;
  logic          w_sub_ovf;

  assign w_sum      = {1'b0, Reg1_Out} + {1'b0, Reg2_Out};
  assign w_diff     = {1'b0, Reg1_Out} - {1'b0, Reg2_Out};
  assign w_step_acc = r_acc + (r_mplier[0] ? r_mcand : '0);

  // Overflow: operands (B inverted for SUB) share a sign and the result differs.
  assign w_add_ovf = (Reg1_Out[W-1] == Reg2_Out[W-1])  && (w_sum[W-1]  != Reg1_Out[W-1]);
  assign w_sub_ovf = (Reg1_Out[W-1] == ~Reg2_Out[W-1]) && (w_diff[W-1] != Reg1_Out[W-1]);

  always_comb begin
    w_state_next  = r_state;
    w_mcand_next  = r_mcand;
    w_mplier_next = r_mplier;
    w_acc_next    = r_acc;
    w_cnt_next    = r_cnt;
    w_out_next    = r_out;
    w_hi_next     = r_hi;
    w_busy_next   = r_busy;
    w_done_next   = 1'b0;
    w_zero_next   = r_zero;
    w_carry_next  = r_carry;
    w_ovf_next    = r_ovf;
    w_err_next    = r_err;

    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (Alu_Op == OP_MUL) begin
            w_mcand_next  = {{W{1'b0}}, Reg1_Out};
            w_mplier_next = Reg2_Out;
            w_acc_next    = '0;
            w_cnt_next    = CNT_WIDTH'(W);
            w_busy_next   = 1'b1;
            w_state_next  = S_MUL;
          end else begin
            w_done_next  = 1'b1;
            w_hi_next    = '0;
            w_carry_next = 1'b0;
            w_ovf_next   = 1'b0;
            w_err_next   = 1'b0;
            case (Alu_Op)
              OP_ADD: begin
                w_out_next   = w_sum[W-1:0];
                w_carry_next = w_sum[W];
                w_ovf_next   = w_add_ovf;
              end
              OP_SUB: begin
                w_out_next   = w_diff[W-1:0];
                w_carry_next = w_diff[W];
                w_ovf_next   = w_sub_ovf;
              end
              OP_PASS: w_out_next = Reg2_Out;
              OP_AND:  w_out_next = Reg1_Out & Reg2_Out;
              OP_OR:   w_out_next = Reg1_Out | Reg2_Out;
              OP_XOR:  w_out_next = Reg1_Out ^ Reg2_Out;
              default: begin
                // Illegal opcode: zero result, flagged as an error.
                w_out_next = '0;
                w_err_next = 1'b1;
              end
            endcase
            w_zero_next = (w_out_next == '0);
          end
        end
      end

      S_MUL: begin
        w_acc_next    = w_step_acc;
        w_mcand_next  = r_mcand << 1;
        w_mplier_next = r_mplier >> 1;
        w_cnt_next    = r_cnt - CNT_WIDTH'(1);
        // Last step: publish the just-completed product on this same edge.
        if (r_cnt == CNT_WIDTH'(1)) begin
          w_state_next = S_IDLE;
          w_busy_next  = 1'b0;
          w_done_next  = 1'b1;
          w_out_next   = w_step_acc[W-1:0];
          w_hi_next    = w_step_acc[PW-1:W];
          w_zero_next  = (w_step_acc == '0);
          w_carry_next = 1'b0;
          w_ovf_next   = (w_step_acc[PW-1:W] != '0);
          w_err_next   = 1'b0;
        end
      end

      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state  <= S_IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_out    <= '0;
      r_hi     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_zero   <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_mcand  <= w_mcand_next;
      r_mplier <= w_mplier_next;
      r_acc    <= w_acc_next;
      r_cnt    <= w_cnt_next;
      r_out    <= w_out_next;
      r_hi     <= w_hi_next;
      r_busy   <= w_busy_next;
      r_done   <= w_done_next;
      r_zero   <= w_zero_next;
      r_carry  <= w_carry_next;
      r_ovf    <= w_ovf_next;
      r_err    <= w_err_next;
    end
  end

  assign Alu_Out = r_out;
  assign Alu_Hi  = r_hi;
  assign Busy    = r_busy;
  assign Done    = r_done;
  assign Zero    = r_zero;
  assign Carry   = r_carry;
  assign Ovf     = r_ovf;
  assign Err     = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq at DATA_WIDTH=8. Directed
// cases followed by random operations, each compared against an arithmetic
// reference model.
// -----------------------------------------------------------------------------
module tb_alu_seq;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Start = 1'b0;
  logic [2:0] Alu_Op = 3'd0;
  logic [7:0] Reg1_Out = 8'd0;
  logic [7:0] Reg2_Out = 8'd0;
  logic [7:0] Alu_Out;
  logic [7:0] Alu_Hi;
  logic       Busy, Done, Zero, Carry, Ovf, Err;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.DATA_WIDTH(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Alu_Op(Alu_Op),
    .Reg1_Out(Reg1_Out), .Reg2_Out(Reg2_Out),
    .Alu_Out(Alu_Out), .Alu_Hi(Alu_Hi), .Busy(Busy), .Done(Done),
    .Zero(Zero), .Carry(Carry), .Ovf(Ovf), .Err(Err)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0] out;
    logic [7:0] hi;
    logic       z;
    logic       c;
    logic       v;
    logic       e;
  } exp_t;

  exp_t last_e;

  // Reference: plain integer arithmetic on the opcode's meaning.
  function automatic exp_t model(input int op, input int a, input int b);
    exp_t r;
    int sa, sb, s, p;
    r  = '0;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      0: begin
        s = a + b; r.out = 8'(s); r.c = (s > 255);
        r.v = ((sa + sb) > 127) || ((sa + sb) < -128);
      end
      1: begin
        s = a - b; r.out = 8'(s); r.c = (a < b);
        r.v = ((sa - sb) > 127) || ((sa - sb) < -128);
      end
      2: begin
        p = a * b; r.out = 8'(p % 256); r.hi = 8'(p / 256);
        r.v = (p / 256) != 0;
      end
      3: r.out = 8'(b);
      4: r.out = 8'(a & b);
      5: r.out = 8'(a | b);
      6: r.out = 8'(a ^ b);
      default: r.e = 1'b1;
    endcase
    if (op == 2) r.z = (a * b) == 0;
    else         r.z = (r.out == 8'd0);
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op now, then count cycles to Done. With poke set, an ADD
  // Start is pulsed while the multiply is busy and must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit poke);
    exp_t e;
    int   cyc, busy_cnt, exp_lat;
    e       = model(int'(op), int'(a), int'(b));
    exp_lat = (op == 3'd2) ? 9 : 1;
    Start = 1'b1; Alu_Op = op; Reg1_Out = a; Reg2_Out = b;
    @(posedge Clk); #1;
    Start = 1'b0;
    Reg1_Out = 8'($urandom); Reg2_Out = 8'($urandom);
    cyc = 1; busy_cnt = 0;
    while (!Done && cyc < 40) begin
      if (Busy) busy_cnt++;
      if (poke && cyc == 3) begin
        Start = 1'b1; Alu_Op = 3'd0;
      end else begin
        Start = 1'b0;
      end
      @(posedge Clk); #1;
      cyc++;
    end
    Start = 1'b0;
    chk("latency", cyc, exp_lat);
    chk("busy_cycles", busy_cnt, exp_lat - 1);
    chk("busy_at_done", Busy, 0);
    chk("alu_out", Alu_Out, e.out);
    chk("alu_hi", Alu_Hi, e.hi);
    chk("flags_zcve", {Zero, Carry, Ovf, Err}, {e.z, e.c, e.v, e.e});
    $display("op=%0d a=%02h b=%02h -> out=%02h hi=%02h z=%0b c=%0b v=%0b e=%0b lat=%0d",
             op, a, b, Alu_Out, Alu_Hi, Zero, Carry, Ovf, Err, cyc);
    last_e = e;
  endtask

  // One idle cycle: Done must have dropped and results must hold.
  task automatic idle_chk();
    @(posedge Clk); #1;
    chk("done_pulse", Done, 0);
    chk("hold_out", {Alu_Out, Alu_Hi}, {last_e.out, last_e.hi});
    chk("hold_flags", {Zero, Carry, Ovf, Err}, {last_e.z, last_e.c, last_e.v, last_e.e});
  endtask

  initial begin
    logic [2:0] op;
    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_outs", {Alu_Out, Alu_Hi}, 16'h0);
    chk("reset_ctl", {Busy, Done, Zero, Carry, Ovf, Err}, 6'h0);
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;

    run_op(3'd0, 8'hFF, 8'h01, 1'b0);
    chk("add_ff01_out", Alu_Out, 8'h00);
    chk("add_ff01_zc", {Zero, Carry, Ovf}, 3'b110);
    idle_chk();
    run_op(3'd1, 8'h80, 8'h01, 1'b0);
    chk("sub_8001", {Alu_Out, Ovf, Carry}, {8'h7F, 1'b1, 1'b0});
    idle_chk();
    run_op(3'd1, 8'h01, 8'h02, 1'b0);
    chk("sub_0102", {Alu_Out, Carry}, {8'hFF, 1'b1});
    idle_chk();
    run_op(3'd2, 8'hFF, 8'hFF, 1'b0);
    chk("mul_ffff", {Alu_Hi, Alu_Out, Ovf}, {8'hFE, 8'h01, 1'b1});
    idle_chk();
    run_op(3'd2, 8'h0C, 8'h0A, 1'b1);
    chk("mul_0c0a", {Alu_Hi, Alu_Out, Ovf}, {8'h00, 8'h78, 1'b0});
    idle_chk();
    idle_chk();

    // Reset 4 cycles into a multiply: outputs clear immediately.
    run_op(3'd4, 8'hF0, 8'h3C, 1'b0);
    Start = 1'b1; Alu_Op = 3'd2; Reg1_Out = 8'h37; Reg2_Out = 8'h55;
    @(posedge Clk); #1;
    Start = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("busy_mid_mul", Busy, 1);
    Rst_n = 1'b0;
    #1;
    chk("async_rst_outs", {Alu_Out, Alu_Hi}, 16'h0);
    chk("async_rst_ctl", {Busy, Done, Zero, Carry, Ovf, Err}, 6'h0);
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;
    run_op(3'd0, 8'h02, 8'h03, 1'b0);
    chk("add_after_rst", Alu_Out, 8'h05);
    idle_chk();

    // Back-to-back: ADD issued in the cycle MUL Done is high.
    run_op(3'd2, 8'h13, 8'h2B, 1'b0);
    run_op(3'd0, 8'h10, 8'h20, 1'b0);
    idle_chk();
    run_op(3'd7, 8'h12, 8'h34, 1'b0);
    chk("illegal", {Err, Zero, Alu_Out}, {1'b1, 1'b1, 8'h00});
    idle_chk();
    run_op(3'd5, 8'h00, 8'h00, 1'b0);
    chk("err_cleared", Err, 0);

    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      run_op(op, 8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0));
      if ($urandom_range(0, 1) == 1) idle_chk();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
